// File: rtl/theta_step_driver.sv
// rtl/theta_step_driver.sv - step/direction pulse generator for the two SCARA joints
//
// Turns a pair of signed 9-bit joint increments into lockstep step pulse trains
// and keeps the commanded joint positions in step units.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   load                  start request, honoured only in IDLE
//   dth1, dth2            signed joint increments in steps
//   busy                  high while a segment executes
//   done                  one-cycle pulse when the segment is complete
//   step1, step2          step pulses to the drivers
//   dir1, dir2            direction, 1 = positive increment
//   th1_pos, th2_pos      signed commanded positions (wrap modulo 2^POS_WIDTH)
module theta_step_driver #(
    parameter int STEP_HALF = 500,
    parameter int DIR_SETUP = 4,
    parameter int POS_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load,
    input  logic signed [8:0]           dth1,
    input  logic signed [8:0]           dth2,
    output logic                        busy,
    output logic                        done,
    output logic                        step1,
    output logic                        step2,
    output logic                        dir1,
    output logic                        dir2,
    output logic signed [POS_WIDTH-1:0] th1_pos,
    output logic signed [POS_WIDTH-1:0] th2_pos
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STEP_HI,
        STEP_LO,
        DONE
    } state_t;

    localparam int CNT_MAX = (STEP_HALF > DIR_SETUP) ? STEP_HALF : DIR_SETUP;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(STEP_HALF - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [9:0]       rem1;
    logic [9:0]       rem2;
    logic             enter_hi;

    // Magnitude of a 9-bit signed value; 10 bits so that -256 maps to 256.
    function automatic logic [9:0] mag(input logic [8:0] d);
        logic [9:0] e;
        e = {d[8], d};
        return d[8] ? (~e + 10'd1) : e;
    endfunction

    function automatic logic [POS_WIDTH-1:0] bump(input logic [POS_WIDTH-1:0] p,
                                                   input logic dir);
        return dir ? (p + POS_WIDTH'(1)) : (p - POS_WIDTH'(1));
    endfunction

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (load) begin
                    state_next = (dth1 == 9'sd0 && dth2 == 9'sd0) ? DONE : SETUP;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_next = STEP_HI;
                end
            end
            STEP_HI: begin
                if (cnt == HALF_LAST) begin
                    state_next = STEP_LO;
                end
            end
            STEP_LO: begin
                if (cnt == HALF_LAST) begin
                    state_next = (rem1 != 10'd0 || rem2 != 10'd0) ? STEP_HI : DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The pulse, count decrement and position update all happen on the edge
    // that enters STEP_HI, so the position moves in the same cycle the step rises.
    assign enter_hi = (state_next == STEP_HI) && (state != STEP_HI);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rem1    <= 10'd0;
            rem2    <= 10'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            step1   <= 1'b0;
            step2   <= 1'b0;
            dir1    <= 1'b0;
            dir2    <= 1'b0;
            th1_pos <= '0;
            th2_pos <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state) ? '0 : cnt + 1'b1;
            busy  <= (state_next == SETUP) || (state_next == STEP_HI) || (state_next == STEP_LO);
            done  <= (state_next == DONE);

            if (state == IDLE && load) begin
                rem1 <= mag(dth1);
                rem2 <= mag(dth2);
                // A zero increment leaves that axis's direction untouched.
                if (dth1 != 9'sd0) begin
                    dir1 <= ~dth1[8];
                end
                if (dth2 != 9'sd0) begin
                    dir2 <= ~dth2[8];
                end
            end

            if (enter_hi) begin
                step1 <= (rem1 != 10'd0);
                step2 <= (rem2 != 10'd0);
                if (rem1 != 10'd0) begin
                    rem1    <= rem1 - 10'd1;
                    th1_pos <= bump(th1_pos, dir1);
                end
                if (rem2 != 10'd0) begin
                    rem2    <= rem2 - 10'd1;
                    th2_pos <= bump(th2_pos, dir2);
                end
            end else if (state_next != STEP_HI) begin
                step1 <= 1'b0;
                step2 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_theta_step_driver.sv
// tb/tb_theta_step_driver.sv - scoreboard bench for theta_step_driver
module tb_theta_step_driver;

    localparam int SH = 2;
    localparam int DS = 2;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              load  = 1'b0;
    logic signed [8:0] dth1  = '0;
    logic signed [8:0] dth2  = '0;

    logic busy_a, done_a, step1_a, step2_a, dir1_a, dir2_a;
    logic signed [15:0] th1_pos_a, th2_pos_a;
    logic busy_b, done_b, step1_b, step2_b, dir1_b, dir2_b;
    logic signed [8:0] th1_pos_b, th2_pos_b;

    theta_step_driver #(.STEP_HALF(SH), .DIR_SETUP(DS), .POS_WIDTH(16)) dut_a (
        .clk(clk), .reset(reset), .load(load), .dth1(dth1), .dth2(dth2),
        .busy(busy_a), .done(done_a), .step1(step1_a), .step2(step2_a),
        .dir1(dir1_a), .dir2(dir2_a), .th1_pos(th1_pos_a), .th2_pos(th2_pos_a)
    );

    theta_step_driver #(.STEP_HALF(SH), .DIR_SETUP(DS), .POS_WIDTH(9)) dut_b (
        .clk(clk), .reset(reset), .load(load), .dth1(dth1), .dth2(dth2),
        .busy(busy_b), .done(done_b), .step1(step1_b), .step2(step2_b),
        .dir1(dir1_b), .dir2(dir2_b), .th1_pos(th1_pos_b), .th2_pos(th2_pos_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int p;
    } rise_t;

    typedef struct {
        int start;
        int fin;
        bit zero;
        bit d1;
        bit d2;
        int p1;
        int p2;
    } seg_t;

    seg_t  seg_q[$];
    rise_t r1_q[$];
    rise_t r2_q[$];
    int    m_p1 = 0, m_p2 = 0;
    bit    m_d1 = 0, m_d2 = 0;
    int    m_last_done = -1;
    int    hi_end1 = -100, hi_end2 = -100;
    int    total = 0, bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic int s16(input int v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    function automatic int s9(input int v);
        logic signed [8:0] t;
        t = v[8:0];
        return int'(t);
    endfunction

    // Reference: a segment accepted in cycle n finishes after the direction
    // setup plus one full step period per step of the longer axis.
    task automatic model_accept(input int n, input int d1, input int d2);
        int a1, a2, k;
        seg_t s;
        a1 = (d1 < 0) ? -d1 : d1;
        a2 = (d2 < 0) ? -d2 : d2;
        k  = (a1 > a2) ? a1 : a2;
        if (d1 > 0) m_d1 = 1; else if (d1 < 0) m_d1 = 0;
        if (d2 > 0) m_d2 = 1; else if (d2 < 0) m_d2 = 0;
        for (int i = 0; i < k; i++) begin
            int c;
            c = n + 1 + DS + 2 * SH * i;
            if (i < a1) begin
                m_p1 += (d1 > 0) ? 1 : -1;
                r1_q.push_back('{c: c, p: m_p1});
            end
            if (i < a2) begin
                m_p2 += (d2 > 0) ? 1 : -1;
                r2_q.push_back('{c: c, p: m_p2});
            end
        end
        s.start = n;
        s.zero  = (k == 0);
        s.fin   = (k == 0) ? n + 1 : n + 1 + DS + 2 * SH * k;
        s.d1    = m_d1;
        s.d2    = m_d2;
        s.p1    = m_p1;
        s.p2    = m_p2;
        seg_q.push_back(s);
        m_last_done = s.fin;
    endtask

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #2;
        end
    endtask

    // Called 2 ns after a rising edge; holds load for exactly one cycle.
    task automatic drive(input int d1, input int d2);
        int n;
        n = cyc;
        load = 1'b1;
        dth1 = 9'(d1);
        dth2 = 9'(d2);
        if (n > m_last_done) model_accept(n, d1, d2);
        tick(1);
        load = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a"}, {busy_a, done_a, step1_a, step2_a, dir1_a, dir2_a, th1_pos_a, th2_pos_a}, 0);
        chk({tag, "_b"}, {busy_b, done_b, step1_b, step2_b, dir1_b, dir2_b, th1_pos_b, th2_pos_b}, 0);
    endtask

    task automatic flush_model();
        seg_q.delete();
        r1_q.delete();
        r2_q.delete();
        m_p1 = 0; m_p2 = 0; m_d1 = 0; m_d2 = 0;
        m_last_done = -1;
        hi_end1 = -100; hi_end2 = -100;
    endtask

    task automatic do_reset();
        #1 reset = 1'b1;
        #1 check_zero("reset_async");
        flush_model();
        tick(2);
        check_zero("reset_held");
        reset = 1'b0;
    endtask

    task automatic wait_quiet();
        int guard;
        guard = 0;
        while (seg_q.size() > 0 && guard < 4000) begin
            @(posedge clk);
            guard++;
        end
        #2;
        chk("quiet_timeout", seg_q.size(), 0);
        if (seg_q.size() > 0) flush_model();
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            bit eb;
            bit has;
            has = (seg_q.size() > 0);
            eb = has && !seg_q[0].zero && cyc >= seg_q[0].start + 1 && cyc < seg_q[0].fin;
            chk("busy_a", busy_a, eb);
            chk("busy_b", busy_b, eb);

            if (r1_q.size() > 0 && r1_q[0].c == cyc) begin
                hi_end1 = cyc + SH - 1;
                chk("pos1_step_a", th1_pos_a, s16(r1_q[0].p));
                chk("pos1_step_b", th1_pos_b, s9(r1_q[0].p));
                if (has) chk("dir1_step", dir1_a, seg_q[0].d1);
                void'(r1_q.pop_front());
            end
            chk("step1_a", step1_a, cyc <= hi_end1);
            chk("step1_b", step1_b, cyc <= hi_end1);

            if (r2_q.size() > 0 && r2_q[0].c == cyc) begin
                hi_end2 = cyc + SH - 1;
                chk("pos2_step_a", th2_pos_a, s16(r2_q[0].p));
                chk("pos2_step_b", th2_pos_b, s9(r2_q[0].p));
                if (has) chk("dir2_step", dir2_a, seg_q[0].d2);
                void'(r2_q.pop_front());
            end
            chk("step2_a", step2_a, cyc <= hi_end2);
            chk("step2_b", step2_b, cyc <= hi_end2);

            if (has && seg_q[0].fin == cyc) begin
                chk("done_a", done_a, 1);
                chk("done_b", done_b, 1);
                chk("dir1_done", {dir1_a, dir1_b}, {seg_q[0].d1, seg_q[0].d1});
                chk("dir2_done", {dir2_a, dir2_b}, {seg_q[0].d2, seg_q[0].d2});
                chk("pos1_done_a", th1_pos_a, s16(seg_q[0].p1));
                chk("pos2_done_a", th2_pos_a, s16(seg_q[0].p2));
                chk("pos1_done_b", th1_pos_b, s9(seg_q[0].p1));
                chk("pos2_done_b", th2_pos_b, s9(seg_q[0].p2));
                void'(seg_q.pop_front());
            end else begin
                chk("done_idle_a", done_a, 0);
                chk("done_idle_b", done_b, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        tick(2);
        check_zero("reset_init");
        reset = 1'b0;
        tick(1);

        // mixed signs from zero
        drive(3, -2);
        wait_quiet();
        chk("mixed_th1", th1_pos_a, 3);
        chk("mixed_th2", th2_pos_a, -2);

        // zero move keeps positions and directions
        drive(0, 0);
        wait_quiet();
        chk("zero_th1", th1_pos_a, 3);
        chk("zero_dir1", dir1_a, 1);

        // extreme magnitude
        do_reset();
        tick(1);
        drive(-256, 0);
        wait_quiet();
        chk("ext_th1", th1_pos_a, -256);
        drive(255, 255);
        wait_quiet();
        chk("ext2_th1", th1_pos_a, -1);
        chk("ext2_th2", th2_pos_a, 255);

        // loads outside IDLE are dropped
        do_reset();
        tick(1);
        n0 = cyc;
        drive(5, 5);
        tick(3);
        drive(1, 1);
        tick(n0 + 1 + DS + 2 * SH * 5 - cyc);
        drive(1, 1);
        wait_quiet();
        chk("ign_th1", th1_pos_a, 5);
        chk("ign_th2", th2_pos_a, 5);

        // reset in the middle of a segment
        do_reset();
        tick(1);
        n0 = cyc;
        drive(4, 4);
        tick(n0 + 6 - cyc);
        do_reset();
        tick(1);
        drive(1, 0);
        wait_quiet();
        chk("after_rst_th1", th1_pos_a, 1);

        // 9-bit position wrap
        do_reset();
        tick(1);
        drive(-256, 0);
        wait_quiet();
        drive(-1, 0);
        wait_quiet();
        chk("wrap_th1_b", th1_pos_b, 255);
        chk("wrap_th1_a", th1_pos_a, -257);

        // random segments with random spacing, some landing while busy
        for (int i = 0; i < 30; i++) begin
            int r1, r2;
            r1 = int'($urandom_range(14)) - 7;
            r2 = int'($urandom_range(14)) - 7;
            if ($urandom_range(7) == 0) begin
                r1 = 0;
                r2 = 0;
            end
            drive(r1, r2);
            tick(int'($urandom_range(40)));
        end
        wait_quiet();
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/theta_step_driver.md
# theta_step_driver

Converts the signed 9-bit joint-angle increments from the inverse-Jacobian stage into step/direction pulse trains for the two SCARA joint stepper drivers, and keeps the commanded joint positions in step units. It sits directly downstream of the matrix-multiply stage. The controller pulses `load` when that stage's `data_ready` rises, with its 9-bit `dth1`/`dth2` outputs on the data inputs. `done` tells the controller that the motion segment has been executed and the next dx/dy may be issued.

## Interface
- `STEP_HALF` — default 500 — clocks per step-high and per step-low phase; ≥1.
- `DIR_SETUP` — default 4 — clocks between a direction update and the first step edge; ≥1.
- `POS_WIDTH` — default 16 — width of the signed position counters.

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `load`  in  1  start request; sampled only in IDLE.
- `dth1`  in  9  signed joint-1 increment, in steps.
- `dth2`  in  9  signed joint-2 increment, in steps.
- `busy`  out  1  high while a segment is executing.
- `done`  out  1  one-cycle pulse at segment completion.
- `step1`, `step2`  out  1  step pulses to the drivers.
- `dir1`, `dir2`  out  1  direction; 1 = positive increment.
- `th1_pos`, `th2_pos`  out  POS_WIDTH  signed commanded position.

## Operation
- **Reset values:** all outputs 0, state IDLE, remaining counts 0, position counters 0.
- **States:** IDLE, SETUP, STEP_HI, STEP_LO, DONE.
- **Load in IDLE:**
  - Latch `rem1 = |dth1|` and `rem2 = |dth2|` as 10-bit unsigned values. -256 gives 256.
  - Latch `dir1`/`dir2` from the sign bits: dir = 1 when delta > 0, dir = 0 when delta < 0.
  - For a zero delta, that dir output keeps its previous value.
  - If both deltas are nonzero-free (both zero), go to DONE. Otherwise go to SETUP.
- **SETUP:** `busy` = 1. Hold for DIR_SETUP cycles, then go to STEP_HI.
- **STEP_HI:**
  - Entry cycle: `stepN` = 1 for every axis with remN > 0.
  - On that same entry, decrement remN and add ±1 to thN_pos by dirN.
  - Hold for STEP_HALF cycles, then go to STEP_LO.
- **STEP_LO:** step outputs 0. Hold for STEP_HALF cycles.
  - Then go to STEP_HI if rem1 or rem2 is still > 0; otherwise go to DONE.
- **Axis behaviour:** both axes step in lockstep on the same edges. The shorter axis simply stops pulsing once its count reaches 0.
- **DONE:** `done` = 1 and `busy` = 0 for exactly one cycle, then IDLE.
- **Position wrap:** positions wrap modulo 2^POS_WIDTH (two's complement); no saturation.
- **Load outside IDLE:** ignored entirely, with no queuing. This includes load asserted during the DONE cycle.
- **Reset mid-segment:** all outputs clear asynchronously, the segment is abandoned, and positions return to 0.
- **Held load:** a `load` held high re-triggers on the first IDLE cycle after DONE. The controller must pulse it.

## Timing
- `load` sampled high at edge N → registered `dir`/`busy` valid in cycle N+1.
- The first step rising edge occurs at cycle N+1+DIR_SETUP.
- Step period is 2·STEP_HALF cycles with 50 % duty.
- With k = max(|dth1|, |dth2|) > 0, `done` is high in cycle N+1+DIR_SETUP+2·STEP_HALF·k.
- Zero/zero segment: `done` is high in cycle N+1 and `busy` never rises.
- Position updates are visible in the same cycle as the corresponding step rising edge.
- `dir` is constant from cycle N+1 through `done`.
- Every output is registered directly; no combinational path from inputs.

## Test plan
All scenarios use STEP_HALF=2 and DIR_SETUP=2; the first four also use POS_WIDTH=16.

- **Reset:** assert `reset` asynchronously between edges → all outputs 0 immediately and remain 0 while `reset` is held.
- **Mixed signs:** load `dth1`=3, `dth2`=-2 at cycle 0. Required response:
  - `dir1`=1, `dir2`=0 at cycle 1.
  - `step1` rises at cycles 3, 7, 11; `step2` rises at 3, 7.
  - `done` pulses at cycle 15.
  - `th1_pos`=3, `th2_pos`=-2.
- **Zero move:** load 0/0 → `done` pulses at cycle 1, no step pulses, `busy` stays 0, positions and `dir` unchanged.
- **Extreme value:** load -256/0 → 256 `step1` pulses, `done` at cycle 1027, `th1_pos`=-256, `dir2` unchanged. Then load 255/255 → `th1_pos`=-1, `th2_pos`=255.
- **Ignored loads:** load 5/5, then pulse `load` with 1/1 at cycles 4 and at the DONE cycle → exactly 5 steps per axis, positions 5/5.
- **Reset mid-step:** load 4/4, assert `reset` at cycle 6 → `step` drops to 0 immediately and positions read 0. After release, load 1/0 → normal single-step segment.
- **Wrap (POS_WIDTH=9):** start from position 0, load -256 then -1 → `th1_pos` wraps to 255 (0x0FF).
